// File: rtl/board_io_ctrl_if.sv
// Register-port bundle between the MicroBlaze bus bridge (master) and board_io_ctrl (slave).
interface board_io_ctrl_if;
  logic        REG_WR;
  logic        REG_RD;
  logic [2:0]  REG_ADDR;
  logic [31:0] REG_WDATA;
  logic [31:0] REG_RDATA;
  logic        REG_RVALID;
  logic        IRQ;

  modport master (
    output REG_WR, REG_RD, REG_ADDR, REG_WDATA,
    input  REG_RDATA, REG_RVALID, IRQ
  );

  modport slave (
    input  REG_WR, REG_RD, REG_ADDR, REG_WDATA,
    output REG_RDATA, REG_RVALID, IRQ
  );
endinterface

// File: rtl/board_io_ctrl.sv
// Board user-I/O controller: synchronised, debounced buttons/switches with latched
// interrupts, and static/blinking LEDs, behind a small 8-register port.
module board_io_ctrl #(
  parameter int NUM_BTN         = 4,
  parameter int NUM_SW          = 4,
  parameter int NUM_LED         = 4,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_BTN-1:0] BTN_IN,
  input  logic [NUM_SW-1:0]  SW_IN,
  output logic [NUM_LED-1:0] LED_OUT,
  board_io_ctrl_if.slave     reg_if
);

  localparam int NUM_IN = NUM_BTN + NUM_SW;
  localparam int DBW    = $clog2(DEBOUNCE_CYCLES);
  localparam int BKW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DBW-1:0]    DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BKW-1:0]    BK_LAST = BKW'(BLINK_DIV - 1);
  localparam logic [NUM_IN-1:0] SW_MASK = {{NUM_SW{1'b1}}, {NUM_BTN{1'b0}}};
  localparam logic [31:0]       VERSION = {8'd1, 8'(NUM_BTN), 8'(NUM_SW), 8'(NUM_LED)};

  typedef enum logic [2:0] {
    ADDR_BTN      = 3'd0,
    ADDR_SW       = 3'd1,
    ADDR_PEND     = 3'd2,
    ADDR_IRQ_EN   = 3'd3,
    ADDR_LED_VAL  = 3'd4,
    ADDR_LED_MODE = 3'd5,
    ADDR_VERSION  = 3'd6,
    ADDR_RSVD     = 3'd7
  } reg_addr_e;

  logic [NUM_IN-1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_IN-1:0]           stable_q, stable_d;
  logic [NUM_IN-1:0][DBW-1:0]  cnt_q, cnt_d;
  logic [NUM_IN-1:0]           pending_q, pending_d, irq_en_q, irq_en_d;
  logic [NUM_LED-1:0]          led_val_q, led_val_d, led_mode_q, led_mode_d;
  logic [NUM_LED-1:0]          led_out_q, led_out_d;
  logic [BKW-1:0]              presc_q, presc_d;
  logic                        phase_q, phase_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic                        rvalid_q, rvalid_d, irq_q, irq_d;

  reg_addr_e         addr;
  logic [31:0]       rd_mux;
  logic [NUM_IN-1:0] events, w1c;
  logic              unused_wdata;

  assign addr         = reg_addr_e'(reg_if.REG_ADDR);
  assign unused_wdata = ^reg_if.REG_WDATA;

  // Synchroniser and per-input debounce; S only follows sync after a full quiet window.
  always_comb begin
    // NOTE: each _d starts from a full default, so no branch below can infer a latch.
    sync1_d  = {SW_IN, BTN_IN};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DBW'(1);
      end
    end
  end

  // Buttons latch on press only; switches latch on any change.
  always_comb begin
    events = (stable_d ^ stable_q) & (stable_d | SW_MASK);
    w1c    = '0;
    if (reg_if.REG_WR && addr == ADDR_PEND) w1c = reg_if.REG_WDATA[NUM_IN-1:0];
    pending_d  = (pending_q & ~w1c) | events;
    irq_en_d   = irq_en_q;
    led_val_d  = led_val_q;
    led_mode_d = led_mode_q;
    if (reg_if.REG_WR) begin
      case (addr)
        ADDR_IRQ_EN:   irq_en_d   = reg_if.REG_WDATA[NUM_IN-1:0];
        ADDR_LED_VAL:  led_val_d  = reg_if.REG_WDATA[NUM_LED-1:0];
        ADDR_LED_MODE: led_mode_d = reg_if.REG_WDATA[NUM_LED-1:0];
        default:       ;
      endcase
    end
  end

  // Read mux sees pre-write state, so a same-cycle RD/WR returns the old value.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_BTN:      rd_mux = 32'(stable_q[NUM_BTN-1:0]);
      ADDR_SW:       rd_mux = 32'(stable_q[NUM_IN-1:NUM_BTN]);
      ADDR_PEND:     rd_mux = 32'(pending_q);
      ADDR_IRQ_EN:   rd_mux = 32'(irq_en_q);
      ADDR_LED_VAL:  rd_mux = 32'(led_val_q);
      ADDR_LED_MODE: rd_mux = 32'(led_mode_q);
      ADDR_VERSION:  rd_mux = VERSION;
      default:       rd_mux = '0;
    endcase
    rdata_d  = reg_if.REG_RD ? rd_mux : rdata_q;
    rvalid_d = reg_if.REG_RD;
    irq_d    = |(pending_q & irq_en_q);
  end

  always_comb begin
    presc_d = presc_q + BKW'(1);
    phase_d = phase_q;
    if (presc_q == BK_LAST) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
    led_out_d = led_val_q & (~led_mode_q | {NUM_LED{phase_q}});
  end

  // NOTE: the debounce counter array is reset with everything else; a stale count
  // surviving reset could accept an input early.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      pending_q  <= '0;
      irq_en_q   <= '0;
      led_val_q  <= '0;
      led_mode_q <= '0;
      led_out_q  <= '0;
      presc_q    <= '0;
      phase_q    <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values whatever the order.
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      irq_en_q   <= irq_en_d;
      led_val_q  <= led_val_d;
      led_mode_q <= led_mode_d;
      led_out_q  <= led_out_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign LED_OUT           = led_out_q;
  assign reg_if.REG_RDATA  = rdata_q;
  assign reg_if.REG_RVALID = rvalid_q;
  assign reg_if.IRQ        = irq_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the register/debounce rules.
module tb_board_io_ctrl;
  localparam int NB = 4, NS = 4, NL = 4, NI = NB + NS;
  localparam int DC = 4, BD = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_in;
  logic [NS-1:0] sw_in;
  logic [NL-1:0] led_out;
  int            checks = 0;
  int            errors = 0;

  board_io_ctrl_if bus ();

  board_io_ctrl #(
    .NUM_BTN(NB), .NUM_SW(NS), .NUM_LED(NL),
    .DEBOUNCE_CYCLES(DC), .BLINK_DIV(BD)
  ) dut (
    .CLK(clk), .RESET(rst_n), .BTN_IN(btn_in), .SW_IN(sw_in),
    .LED_OUT(led_out), .reg_if(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NI-1:0] m_state;          // debounced {sw, btn}
  int            m_run [NI];       // consecutive cycles sync has disagreed with m_state
  logic [NI-1:0] m_pipe [$];       // raw samples still travelling through the synchroniser
  logic [NI-1:0] m_pending, m_irq_en;
  logic [NL-1:0] m_led_val, m_led_mode, m_led_out;
  logic [31:0]   m_rdata;
  logic          m_rvalid, m_irq;
  longint        m_cycles;

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_state[NB-1:0]);
      3'd1:    return 32'(m_state[NI-1:NB]);
      3'd2:    return 32'(m_pending);
      3'd3:    return 32'(m_irq_en);
      3'd4:    return 32'(m_led_val);
      3'd5:    return 32'(m_led_mode);
      3'd6:    return {8'd1, 8'(NB), 8'(NS), 8'(NL)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = '0;
    foreach (m_run[i]) m_run[i] = 0;
    m_pipe.delete();
    m_pipe.push_back('0);
    m_pipe.push_back('0);
    m_pending = '0; m_irq_en = '0; m_led_val = '0; m_led_mode = '0; m_led_out = '0;
    m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0; m_cycles = 0;
  endtask

  task automatic model_step();
    logic [NI-1:0] sync, new_state, ev, clr;
    bit            phase;
    phase = ((m_cycles / BD) % 2) == 1;
    for (int k = 0; k < NL; k++) m_led_out[k] = m_led_val[k] && (!m_led_mode[k] || phase);
    m_irq    = |(m_pending & m_irq_en);
    if (bus.REG_RD) m_rdata = m_reg(bus.REG_ADDR);
    m_rvalid = bus.REG_RD;
    sync = m_pipe.pop_front();
    m_pipe.push_back({sw_in, btn_in});
    new_state = m_state;
    for (int i = 0; i < NI; i++) begin
      if (sync[i] == m_state[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          new_state[i] = sync[i];
          m_run[i]     = 0;
        end
      end
    end
    ev  = (new_state ^ m_state) & (new_state | {{NS{1'b1}}, {NB{1'b0}}});
    clr = (bus.REG_WR && bus.REG_ADDR == 3'd2) ? bus.REG_WDATA[NI-1:0] : '0;
    m_pending = (m_pending & ~clr) | ev;
    if (bus.REG_WR) begin
      if (bus.REG_ADDR == 3'd3) m_irq_en   = bus.REG_WDATA[NI-1:0];
      if (bus.REG_ADDR == 3'd4) m_led_val  = bus.REG_WDATA[NL-1:0];
      if (bus.REG_ADDR == 3'd5) m_led_mode = bus.REG_WDATA[NL-1:0];
    end
    m_state = new_state;
    m_cycles++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_led_out", 32'(led_out),          32'(m_led_out));
      check("cmp_rdata",   bus.REG_RDATA,         m_rdata);
      check("cmp_rvalid",  32'(bus.REG_RVALID),   32'(m_rvalid));
      check("cmp_irq",     32'(bus.IRQ),          32'(m_irq));
    end
  end

  // ---------------- stimulus helpers (entered and left at a negedge) ----------------
  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    bus.REG_ADDR = a; bus.REG_WDATA = d; bus.REG_WR = 1'b1;
    @(negedge clk);
    bus.REG_WR = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    bus.REG_ADDR = a; bus.REG_RD = 1'b1;
    @(negedge clk);
    bus.REG_RD = 1'b0;
    check("rvalid_one_cycle", 32'(bus.REG_RVALID), 32'h1);
    d = bus.REG_RDATA;
  endtask

  logic [31:0] d;
  logic [3:0]  vals [30];
  int          first, c1;

  initial begin
    btn_in = '0; sw_in = '0;
    bus.REG_WR = 1'b0; bus.REG_RD = 1'b0; bus.REG_ADDR = '0; bus.REG_WDATA = '0;

    // Reset held while everything toggles
    repeat (4) begin
      @(negedge clk);
      btn_in = 4'($urandom); sw_in = 4'($urandom);
      bus.REG_RD = 1'b1; bus.REG_WR = 1'b1; bus.REG_ADDR = 3'd4; bus.REG_WDATA = '1;
    end
    @(negedge clk);
    check("rst_led_out", 32'(led_out), 32'h0);
    check("rst_rvalid",  32'(bus.REG_RVALID), 32'h0);
    check("rst_rdata",   bus.REG_RDATA, 32'h0);
    check("rst_irq",     32'(bus.IRQ), 32'h0);
    btn_in = '0; sw_in = '0; bus.REG_RD = 1'b0; bus.REG_WR = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    reg_read(3'd6, d);
    check("version", d, 32'h0104_0404);

    // Glitch one cycle shorter than the debounce window is dropped
    btn_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    reg_read(3'd0, d); check("glitch_btn_state", d, 32'h0);
    reg_read(3'd2, d); check("glitch_pending",   d, 32'h0);

    // Held press: state lands on edge 6, so a read streamed every cycle sees it on edge 7
    btn_in[0] = 1'b1; bus.REG_ADDR = 3'd0; bus.REG_RD = 1'b1; first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (first == 0 && bus.REG_RDATA[0]) first = k;
    end
    bus.REG_RD = 1'b0;
    check("debounce_latency", 32'(first), 32'd7);
    reg_read(3'd2, d); check("press_pending", d, 32'h1);
    btn_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    reg_read(3'd2, d); check("release_pending", d, 32'h1);
    reg_read(3'd0, d); check("release_state",   d, 32'h0);
    reg_write(3'd2, 32'h1);

    // Switch change raises IRQ when enabled
    reg_write(3'd3, 32'h10);
    sw_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("sw_irq", 32'(bus.IRQ), 32'h1);
    reg_read(3'd2, d); check("sw_pending", d, 32'h10);
    reg_write(3'd2, 32'h10);
    check("irq_lags_clear", 32'(bus.IRQ), 32'h1);
    @(negedge clk);
    check("irq_cleared", 32'(bus.IRQ), 32'h0);
    reg_read(3'd2, d); check("pending_cleared", d, 32'h0);

    // Switch update and W1C on the same edge: the set wins
    sw_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    reg_write(3'd2, 32'h10);
    reg_read(3'd2, d); check("set_beats_clear", d, 32'h10);
    reg_write(3'd2, 32'h10);

    // Blinking LEDs
    reg_write(3'd4, 32'hF);
    reg_write(3'd5, 32'h5);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      vals[i] = led_out;
    end
    c1 = -1;
    for (int i = 1; i < 30; i++) begin
      check("blink_value", 32'(vals[i] == 4'hA || vals[i] == 4'hF), 32'h1);
      if (c1 < 0 && vals[i] != vals[i-1]) c1 = i;
    end
    check("blink_toggle_seen", 32'(c1 > 0), 32'h1);
    if (c1 < 1) c1 = 1;
    check("blink_hold_8",   32'(vals[c1+7]), 32'(vals[c1]));
    check("blink_flip_at_8", 32'(vals[c1+8] ^ vals[c1]), 32'h5);
    reg_write(3'd5, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("static_led", 32'(led_out), 32'hF);
    end

    // RO / reserved registers ignore writes
    reg_write(3'd0, '1);
    reg_write(3'd1, '1);
    reg_write(3'd7, '1);
    reg_read(3'd0, d); check("ro_btn",   d, 32'h0);
    reg_read(3'd1, d); check("ro_sw",    d, 32'h0);
    reg_read(3'd7, d); check("rsvd",     d, 32'h0);

    // Same-cycle RD and WR: old value now, new value next
    bus.REG_ADDR = 3'd4; bus.REG_WDATA = 32'h3; bus.REG_WR = 1'b1; bus.REG_RD = 1'b1;
    @(negedge clk);
    bus.REG_WR = 1'b0; bus.REG_RD = 1'b0;
    check("rdwr_old", bus.REG_RDATA, 32'hF);
    reg_read(3'd4, d); check("rdwr_new", d, 32'h3);

    // Async reset mid-debounce, mid-blink and mid-read
    reg_write(3'd5, 32'h5);
    btn_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    bus.REG_ADDR = 3'd6; bus.REG_RD = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_led_out", 32'(led_out), 32'h0);
    check("async_rdata",   bus.REG_RDATA, 32'h0);
    check("async_rvalid",  32'(bus.REG_RVALID), 32'h0);
    @(negedge clk);
    bus.REG_RD = 1'b0;
    check("no_rvalid_after_reset", 32'(bus.REG_RVALID), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    reg_read(3'd4, d); check("post_rst_led_val",  d, 32'h0);
    reg_read(3'd5, d); check("post_rst_led_mode", d, 32'h0);
    repeat (10) @(negedge clk);
    reg_read(3'd0, d); check("post_rst_btn",     d, 32'h2);
    reg_read(3'd2, d); check("post_rst_pending", d, 32'h2);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int b;
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, NI - 1);
        if (b < NB) btn_in[b] = ~btn_in[b];
        else        sw_in[b-NB] = ~sw_in[b-NB];
      end
      bus.REG_RD    = 1'($urandom_range(0, 1));
      bus.REG_WR    = ($urandom_range(0, 3) == 0);
      bus.REG_ADDR  = 3'($urandom);
      bus.REG_WDATA = $urandom;
    end
    @(negedge clk);
    bus.REG_RD = 1'b0; bus.REG_WR = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Parametrised board user-I/O controller for push buttons, DIP switches and LEDs, with a simple register port for the MicroBlaze bus bridge.
- Generalises fixed 4-bit button/switch/LED GPIO to N channels each.
- Adds per-input synchronisation and debounce, press/change interrupt latching with per-bit enable, and per-LED static or blink mode.

Parameters:
- NUM_BTN, 4, number of push-button inputs (1..16).
- NUM_SW, 4, number of DIP-switch inputs (1..16); NUM_BTN+NUM_SW <= 32.
- NUM_LED, 4, number of LED outputs (1..32).
- DEBOUNCE_CYCLES, 65536, cycles an input must hold a new level before acceptance (>=2); counter width = clog2(DEBOUNCE_CYCLES).
- BLINK_DIV, 25000000, CLK cycles per blink half-period (>=1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous active-low reset; deassertion is synchronous to CLK upstream.
- BTN_IN  in  NUM_BTN  raw push buttons, asynchronous, active-high.
- SW_IN  in  NUM_SW  raw DIP switches, asynchronous.
- LED_OUT  out  NUM_LED  LED drive, active-high.
- REG_WR  in  1  write strobe, one cycle.
- REG_RD  in  1  read strobe, one cycle.
- REG_ADDR  in  3  register index.
- REG_WDATA  in  32  write data.
- REG_RDATA  out  32  read data.
- REG_RVALID  out  1  read data valid.
- IRQ  out  1  level interrupt, registered.

Behaviour:
- Reset (RESET=0, async): all synchroniser flops, debounced state, counters, PENDING, IRQ_EN, LED_VAL, LED_MODE, blink prescaler/phase, LED_OUT, REG_RDATA, REG_RVALID and IRQ = 0. Reset mid-debounce or mid-read discards the operation; no RVALID follows.
- Sync: each input passes through a 2-flop synchroniser.
- Debounce, per input, with stable state S and counter C:
  - sync==S -> C=0.
  - Otherwise C increments each cycle; when C==DEBOUNCE_CYCLES-1, S<=sync and C<=0.
  - A glitch shorter than the window resets C and leaves S unchanged.
  - Raw edge to S update latency = 2 + DEBOUNCE_CYCLES cycles.
- Events:
  - Button rising S edge sets PENDING[i].
  - Switch S change in either direction sets PENDING[NUM_BTN+j].
  - Button falling edges are ignored.
- Registers, unused upper bits read 0:
  - 0 BTN_STATE (RO) debounced buttons.
  - 1 SW_STATE (RO) debounced switches.
  - 2 PENDING (RW1C) writing 1 clears a bit.
  - 3 IRQ_EN (RW).
  - 4 LED_VAL (RW).
  - 5 LED_MODE (RW) 0=static, 1=blink.
  - 6 VERSION (RO) = {8'd1, 8'(NUM_BTN), 8'(NUM_SW), 8'(NUM_LED)}.
  - 7 reserved, reads 0, writes ignored.
- Writes to RO registers are ignored. Writes take effect the cycle after REG_WR.
- Simultaneous event set and W1C clear on the same bit: set wins, bit stays 1.
- Read: REG_RD samples REG_ADDR; REG_RDATA and REG_RVALID are registered 1 cycle later; RVALID is a one-cycle pulse and REG_RDATA holds until the next read. REG_RD and REG_WR in the same cycle: the write is performed and the read returns the pre-write value.
- Back-to-back reads are allowed every cycle.
- IRQ: registered |(PENDING & IRQ_EN), valid 1 cycle after a PENDING or IRQ_EN change.
- Blink: prescaler counts 0..BLINK_DIV-1 and toggles PHASE on wrap; free-running from reset.
- LED_OUT[k] (registered, 1-cycle latency) = LED_VAL[k] & (~LED_MODE[k] | PHASE).

Test Plan:
- Reset with DEBOUNCE_CYCLES=4, BLINK_DIV=8; hold RESET low, toggle inputs -> all outputs 0. Read reg 6 -> 0x01040404 with RVALID exactly 1 cycle after REG_RD.
- Debounce:
  - BTN_IN[0] high 3 cycles then low -> BTN_STATE stays 0, PENDING 0.
  - BTN_IN[0] held high -> BTN_STATE[0]=1 at cycle 6 after the edge, PENDING=0x1.
  - Release -> PENDING stays 0x1.
- Interrupt:
  - IRQ_EN=0x10, SW_IN[0] toggles -> PENDING=0x10, IRQ=1 next cycle.
  - Write PENDING=0x10 -> PENDING=0, IRQ=0.
  - Repeat with a new switch change landing in the same cycle as the W1C -> PENDING stays 0x10.
- LEDs:
  - LED_VAL=0xF, LED_MODE=0x5 -> LED_OUT alternates 0xA/0xF every 8 cycles.
  - LED_MODE=0 -> LED_OUT constant 0xF.
- Register edge cases:
  - Write 0xFFFFFFFF to regs 0, 1, 7 -> reads unchanged/0.
  - Simultaneous RD/WR on reg 4 -> old value returned, new value read next.
- Async reset asserted mid-debounce and mid-blink -> all state 0 immediately; after release, behaviour restarts from zero.
